// File: rtl/hazard_sequencer_if.sv
// Signal bundle between the ID-stage pipeline and the hazard sequencer.
// The master side is the pipeline (drives hazard inputs); the slave side is the sequencer.
interface hazard_sequencer_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       if_id_rs;
   logic [4:0]       if_id_rt;
   logic [5:0]       id_opcode;
   logic             id_ex_memread;
   logic [4:0]       id_ex_rt;
   logic             ex_mem_branch;
   logic             ex_mem_zero;
   logic             dmem_req;
   logic             dmem_ack;
   logic             pc_write;
   logic             if_id_write;
   logic             pipe_en;
   logic             ctrl_bubble;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [1:0]       state;

   modport master (
      output if_id_rs, if_id_rt, id_opcode, id_ex_memread, id_ex_rt,
             ex_mem_branch, ex_mem_zero, dmem_req, dmem_ack,
      input  pc_write, if_id_write, pipe_en, ctrl_bubble, if_id_flush,
             id_ex_flush, ex_mem_flush, mem_err, stall_cnt, state
   );

   modport slave (
      input  if_id_rs, if_id_rt, id_opcode, id_ex_memread, id_ex_rt,
             ex_mem_branch, ex_mem_zero, dmem_req, dmem_ack,
      output pc_write, if_id_write, pipe_en, ctrl_bubble, if_id_flush,
             id_ex_flush, ex_mem_flush, mem_err, stall_cnt, state
   );
endinterface

// File: rtl/hazard_sequencer.sv
// Load-use / taken-branch / slow-memory stall sequencer for the 5-stage MIPS pipe.
// Mealy outputs; priority branch > memory wait > load-use in every state.
module hazard_sequencer #(
   parameter int unsigned LU_CYCLES   = 1,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   hazard_sequencer_if.slave  hz
);
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       lu_cnt_q, lu_cnt_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic br_taken, mem_wait, uses_rt, lu_hazard;
   logic pc_write, if_id_write, pipe_en, ctrl_bubble, flush;

   assign br_taken  = hz.ex_mem_branch & hz.ex_mem_zero;
   assign mem_wait  = hz.dmem_req & ~hz.dmem_ack;
   assign uses_rt   = (hz.id_opcode == 6'b000000) || (hz.id_opcode == 6'b000100) ||
                      (hz.id_opcode == 6'b101011);
   assign lu_hazard = hz.id_ex_memread && (hz.id_ex_rt != 5'd0) &&
                      ((hz.id_ex_rt == hz.if_id_rs) || (uses_rt && (hz.id_ex_rt == hz.if_id_rt)));

   always_comb begin
      state_d     = state_q;
      lu_cnt_d    = lu_cnt_q;
      wait_cnt_d  = '0;
      mem_err_d   = mem_err_q;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      pipe_en     = 1'b1;
      ctrl_bubble = 1'b0;
      flush       = 1'b0;

      if (br_taken) begin
         flush    = 1'b1;
         lu_cnt_d = '0;
         state_d  = RUN;
      end else if (mem_wait) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_en     = 1'b0;
         state_d     = MEM_WAIT;
         if (state_q != MEM_WAIT) begin
            wait_cnt_d = 16'd1;
         end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
         end else begin
            wait_cnt_d = wait_cnt_q;
         end
         if (wait_cnt_d >= 16'(MEM_TIMEOUT)) begin
            mem_err_d = 1'b1;
         end
      end else if (lu_cnt_q != '0) begin
         // lu_cnt is nonzero only in LU_STALL or in a MEM_WAIT that preempted it,
         // so an ack cycle resumes the interrupted bubble sequence here.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         ctrl_bubble = 1'b1;
         lu_cnt_d    = lu_cnt_q - 2'd1;
         state_d     = (lu_cnt_d == '0) ? RUN : LU_STALL;
      end else if (lu_hazard) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         ctrl_bubble = 1'b1;
         if (LU_CYCLES > 1) begin
            lu_cnt_d = 2'(LU_CYCLES - 1);
            state_d  = LU_STALL;
         end else begin
            state_d = RUN;
         end
      end else begin
         state_d = RUN;
      end

      stall_cnt_d = stall_cnt_q;
      if (!pc_write && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         lu_cnt_q    <= '0;
         wait_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         lu_cnt_q    <= lu_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.pc_write     = rst_n & pc_write;
   assign hz.if_id_write  = rst_n & if_id_write;
   assign hz.pipe_en      = rst_n & pipe_en;
   assign hz.ctrl_bubble  = ~rst_n | ctrl_bubble;
   assign hz.if_id_flush  = rst_n & flush;
   assign hz.id_ex_flush  = rst_n & flush;
   assign hz.ex_mem_flush = rst_n & flush;
   assign hz.mem_err      = mem_err_q;
   assign hz.stall_cnt    = stall_cnt_q;
   assign hz.state        = state_q;
endmodule
